calib_window_avg: RTL and testbench

//  Calibration-colour extractor for the face-blocker pixel path. Tracks the raster

---
 rtl/calib_window_avg.sv | 200 ++++++++++++++++++++
 tb/tb_calib_window_avg.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/calib_window_avg.sv
`default_nettype none
// ============================================================================
// Module   : calib_window_avg
// Purpose  : Calibration-colour extractor for the face-blocker pixel path.
//            It tracks the raster address of an RGB565 pixel stream. While
//            calibration is enabled, it averages a 2^WIN_LOG2W x 2^WIN_LOG2H
//            window per channel, starting at (WIN_X0, WIN_Y0). The result is
//            the reference skin colour passed to the colour-match stage.
// Ports    : clk        - system clock, rising edge
//            reset      - synchronous active-high reset
//            ready      - one pixel presented this cycle, advances address
//            reset_addr - force raster address to (0,0), beats ready
//            c_enable   - calibration enable (level)
//            valid      - in_pixel carries real data in a ready cycle
//            in_pixel   - RGB565 {R[15:11],G[10:5],B[4:0]}
//            avg_pixel  - latest accepted window average
//            avg_done   - 1-cycle pulse when avg_pixel updates
//            sample_err - 1-cycle pulse when a window is discarded
//            busy       - high while accumulating a window
// Revision : 1.0 - initial release
// ============================================================================
module calib_window_avg #(
  parameter int          H_RES         = 320,
  parameter int          V_RES         = 240,
  parameter int          WIN_X0        = 156,
  parameter int          WIN_Y0        = 116,
  parameter int          WIN_LOG2W     = 3,
  parameter int          WIN_LOG2H     = 3,
  parameter logic [15:0] DEFAULT_PIXEL = 16'h838E
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic        reset_addr,
  input  logic        c_enable,
  input  logic        valid,
  input  logic [15:0] in_pixel,
  output logic [15:0] avg_pixel,
  output logic        avg_done,
  output logic        sample_err,
  output logic        busy
);

  localparam int X_W  = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W  = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int SH   = WIN_LOG2W + WIN_LOG2H;
  localparam int SR_W = 5 + SH;
  localparam int SG_W = 6 + SH;

  localparam logic [X_W-1:0] X_LO  = X_W'(WIN_X0);
  localparam logic [X_W-1:0] X_HI  = X_W'(WIN_X0 + (1 << WIN_LOG2W) - 1);
  localparam logic [Y_W-1:0] Y_LO  = Y_W'(WIN_Y0);
  localparam logic [Y_W-1:0] Y_HI  = Y_W'(WIN_Y0 + (1 << WIN_LOG2H) - 1);
  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [SR_W-1:0]   sum_r_q, sum_r_d;
  logic [SG_W-1:0]   sum_g_q, sum_g_d;
  logic [SR_W-1:0]   sum_b_q, sum_b_d;
  logic              bad_q, bad_d;
  logic [15:0]       avg_q, avg_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              collect;

  // Window membership of the pixel presented this cycle.
  logic hit, last_px, frame_start;
  assign hit         = ready && (x_q >= X_LO) && (x_q <= X_HI) &&
                       (y_q >= Y_LO) && (y_q <= Y_HI);
  assign last_px     = hit && (x_q == X_HI) && (y_q == Y_HI);
  assign frame_start = ready && (x_q == '0) && (y_q == '0);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sum_r_d = sum_r_q;
    sum_g_d = sum_g_q;
    sum_b_d = sum_b_q;
    bad_d   = bad_q;
    avg_d   = avg_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    collect = 1'b0;

    // Raster address; reset_addr wins over ready.
    if (reset_addr) begin
      x_d = '0;
      y_d = '0;
    end else if (ready) begin
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (c_enable) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!c_enable) begin
          state_d = ST_IDLE;
        end else if (frame_start) begin
          // Fresh window; a window anchored at (0,0) also takes this pixel.
          sum_r_d = '0;
          sum_g_d = '0;
          sum_b_d = '0;
          bad_d   = 1'b0;
          state_d = ST_ACCUM;
          collect = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (!c_enable) begin
          state_d = ST_IDLE;
        end else if (reset_addr) begin
          // Raster restarted under us: the partial window is unusable.
          state_d = ST_ARMED;
          err_d   = 1'b1;
        end else begin
          collect = 1'b1;
        end
      end
      ST_DONE: begin
        if (bad_q) begin
          err_d = 1'b1;
        end else begin
          // Window size is a power of two, so the top bits are the average.
          avg_d  = {sum_r_q[SR_W-1 -: 5], sum_g_q[SG_W-1 -: 6],
                    sum_b_q[SR_W-1 -: 5]};
          done_d = 1'b1;
        end
        state_d = c_enable ? ST_ARMED : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (collect && hit) begin
      if (valid) begin
        sum_r_d = sum_r_d + SR_W'(in_pixel[15:11]);
        sum_g_d = sum_g_d + SG_W'(in_pixel[10:5]);
        sum_b_d = sum_b_d + SR_W'(in_pixel[4:0]);
      end else begin
        bad_d = 1'b1;
      end
      if (last_px) state_d = ST_DONE;
    end

    busy_d = (state_d == ST_ACCUM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sum_r_q <= '0;
      sum_g_q <= '0;
      sum_b_q <= '0;
      bad_q   <= 1'b0;
      avg_q   <= DEFAULT_PIXEL;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sum_r_q <= sum_r_d;
      sum_g_q <= sum_g_d;
      sum_b_q <= sum_b_d;
      bad_q   <= bad_d;
      avg_q   <= avg_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign avg_pixel  = avg_q;
  assign avg_done   = done_q;
  assign sample_err = err_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_calib_window_avg.sv
`default_nettype none
// ============================================================================
// Module   : tb_calib_window_avg
// Purpose  : Self-checking bench for calib_window_avg on a reduced raster
//            (20x14, 8x8 window at (6,3)). Every cycle is compared against a
//            behavioural model that collects window pixels into queues and
//            averages them by division. Table rows and directed sequences
//            add frame-level expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calib_window_avg;

  localparam int H   = 20;
  localparam int V   = 14;
  localparam int X0  = 6;
  localparam int Y0  = 3;
  localparam int LW  = 3;
  localparam int LH  = 3;
  localparam int WW  = 1 << LW;
  localparam int WH  = 1 << LH;
  localparam int NPX = WW * WH;
  localparam int FRAME    = H * V;
  localparam int LAST_IDX = (Y0 + WH - 1) * H + (X0 + WW - 1);
  localparam logic [15:0] DEF = 16'h838E;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready = 1'b0;
  logic        reset_addr = 1'b0;
  logic        c_enable = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] in_pixel = 16'h0000;
  logic [15:0] avg_pixel;
  logic        avg_done, sample_err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  calib_window_avg #(
    .H_RES(H), .V_RES(V), .WIN_X0(X0), .WIN_Y0(Y0),
    .WIN_LOG2W(LW), .WIN_LOG2H(LH), .DEFAULT_PIXEL(DEF)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready), .reset_addr(reset_addr),
    .c_enable(c_enable), .valid(valid), .in_pixel(in_pixel),
    .avg_pixel(avg_pixel), .avg_done(avg_done), .sample_err(sample_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 disabled, 1 waiting for frame start, 2 collecting, 3 finishing
  int          m_x, m_y, m_phase;
  int          m_r[$], m_g[$], m_b[$];
  bit          m_bad;
  logic [15:0] m_avg;
  bit          e_done, e_err, e_busy;

  task automatic model_reset();
    m_x = 0; m_y = 0; m_phase = 0; m_bad = 0; m_avg = DEF;
    m_r.delete(); m_g.delete(); m_b.delete();
    e_done = 0; e_err = 0; e_busy = 0;
  endtask

  task automatic model_step(input bit rdy, input bit ra, input bit ce,
                            input bit vl, input logic [15:0] px);
    bit in_win, is_last, start, take;
    int sr, sg, sb;
    in_win  = rdy && m_x >= X0 && m_x < X0 + WW && m_y >= Y0 && m_y < Y0 + WH;
    is_last = in_win && m_x == X0 + WW - 1 && m_y == Y0 + WH - 1;
    start   = rdy && m_x == 0 && m_y == 0;
    e_done = 0; e_err = 0; take = 0;
    case (m_phase)
      0: if (ce) m_phase = 1;
      1: if (!ce) m_phase = 0;
         else if (start) begin
           m_r.delete(); m_g.delete(); m_b.delete();
           m_bad = 0; m_phase = 2; take = 1;
         end
      2: if (!ce) m_phase = 0;
         else if (ra) begin m_phase = 1; e_err = 1; end
         else take = 1;
      default: begin
        if (m_bad) e_err = 1;
        else begin
          sr = 0; sg = 0; sb = 0;
          foreach (m_r[i]) begin sr += m_r[i]; sg += m_g[i]; sb += m_b[i]; end
          m_avg  = {5'(sr / NPX), 6'(sg / NPX), 5'(sb / NPX)};
          e_done = 1;
        end
        m_phase = ce ? 1 : 0;
      end
    endcase
    if (take && in_win) begin
      if (vl) begin
        m_r.push_back(int'(px[15:11]));
        m_g.push_back(int'(px[10:5]));
        m_b.push_back(int'(px[4:0]));
      end else m_bad = 1;
      if (is_last) m_phase = 3;
    end
    if (ra) begin m_x = 0; m_y = 0; end
    else if (rdy) begin
      m_x++;
      if (m_x == H) begin m_x = 0; m_y++; if (m_y == V) m_y = 0; end
    end
    e_busy = (m_phase == 2);
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    n_checks++;
    if ({avg_pixel, avg_done, sample_err, busy} !== {m_avg, e_done, e_err, e_busy}) begin
      n_fail++;
      $display("FAIL model_cmp: got avg=%h done=%b err=%b busy=%b expected avg=%h done=%b err=%b busy=%b at %0t",
               avg_pixel, avg_done, sample_err, busy, m_avg, e_done, e_err, e_busy, $time);
    end
  endtask

  task automatic cycle(input bit rdy, input bit ra, input bit ce,
                       input bit vl, input logic [15:0] px);
    ready = rdy; reset_addr = ra; c_enable = ce; valid = vl; in_pixel = px;
    @(posedge clk);
    model_step(rdy, ra, ce, vl, px);
    #1;
    check_cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1; ready = 0; reset_addr = 0; valid = 0;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
    check_cycle();
  endtask

  // Drive pixels [first, last) of a frame. pat 0: constant val in window,
  // pat 1: alternating 0000/07FF in window. Outside the window pixels are random.
  task automatic drive_px(input int first, input int last, input bit ce,
                          input int pat, input logic [15:0] val, input int drop,
                          output int n_done, output int n_err, output int done_at);
    int x, y, k;
    logic [15:0] px;
    bit vl;
    n_done = 0; n_err = 0; done_at = -1;
    for (int i = first; i < last; i++) begin
      x = i % H; y = i / H;
      if (x >= X0 && x < X0 + WW && y >= Y0 && y < Y0 + WH) begin
        k  = (y - Y0) * WW + (x - X0);
        px = (pat == 1) ? ((k % 2 == 0) ? 16'h0000 : 16'h07FF) : val;
        vl = (i != drop);
      end else begin
        px = 16'($urandom);
        vl = 1'($urandom);
      end
      cycle(1, 0, ce, vl, px);
      if (avg_done)   begin n_done++; done_at = i; end
      if (sample_err) n_err++;
    end
  endtask

  typedef struct {
    int          pat;
    logic [15:0] val;
    int          drop;
    logic [15:0] exp_avg;
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int nd, ne, da;
    bit ce_r;

    vecs[0] = '{0, 16'hF800, -1, 16'hF800, 1, 0};
    vecs[1] = '{1, 16'h0000, -1, 16'h03EF, 1, 0};
    vecs[2] = '{0, 16'h001F, -1, 16'h001F, 1, 0};
    vecs[3] = '{0, 16'h1234, (Y0 + 4) * H + X0 + 4, 16'h001F, 0, 1};
    vecs[4] = '{0, 16'h1234, -1, 16'h1234, 1, 0};

    model_reset();
    repeat (2) @(posedge clk);
    do_reset();
    chk("reset_avg", int'(avg_pixel), int'(DEF));
    chk("reset_busy", int'(busy), 0);

    // Disabled for a full frame: no pulses, default colour kept.
    drive_px(0, FRAME, 0, 0, 16'hFFFF, -1, nd, ne, da);
    chk("disabled_done", nd, 0);
    chk("disabled_err", ne, 0);
    chk("disabled_avg", int'(avg_pixel), int'(DEF));

    // Arm, then run one enabled frame per table row.
    cycle(0, 0, 1, 0, 16'h0);
    foreach (vecs[r]) begin
      drive_px(0, FRAME, 1, vecs[r].pat, vecs[r].val, vecs[r].drop, nd, ne, da);
      chk($sformatf("row%0d_avg", r), int'(avg_pixel), int'(vecs[r].exp_avg));
      chk($sformatf("row%0d_done", r), nd, vecs[r].exp_done);
      chk($sformatf("row%0d_err", r), ne, vecs[r].exp_err);
      if (vecs[r].exp_done == 1)
        chk($sformatf("row%0d_done_at", r), da, LAST_IDX + 1);
    end

    // Drop c_enable mid-window: silent abort.
    drive_px(0, 150, 1, 0, 16'h7777, -1, nd, ne, da);
    chk("mid_window_busy", int'(busy), 1);
    cycle(0, 0, 0, 1, 16'h0);
    chk("abort_busy", int'(busy), 0);
    drive_px(150, FRAME, 0, 0, 16'h7777, -1, nd, ne, da);
    chk("abort_pulses", nd + ne, 0);
    chk("abort_avg", int'(avg_pixel), 16'h1234);

    // reset_addr mid-window: error pulse, address back to (0,0).
    cycle(0, 0, 1, 0, 16'h0);
    drive_px(0, 150, 1, 0, 16'h7777, -1, nd, ne, da);
    cycle(0, 1, 1, 0, 16'h0);
    chk("ra_abort_err", int'(sample_err), 1);
    chk("ra_abort_busy", int'(busy), 0);
    drive_px(0, FRAME, 1, 0, 16'h5555, -1, nd, ne, da);
    chk("ra_restart_done_at", da, LAST_IDX + 1);
    chk("ra_restart_avg", int'(avg_pixel), 16'h5555);

    // ready + reset_addr together at (5,0) gives (0,0) next.
    drive_px(0, 5, 0, 0, 16'h0, -1, nd, ne, da);
    cycle(1, 1, 0, 1, 16'h0);
    cycle(0, 0, 1, 0, 16'h0);
    drive_px(0, FRAME, 1, 0, 16'h2108, -1, nd, ne, da);
    chk("ra_ready_done_at", da, LAST_IDX + 1);
    chk("ra_ready_avg", int'(avg_pixel), 16'h2108);

    // Reset in the middle of accumulation.
    drive_px(0, 150, 1, 0, 16'h4444, -1, nd, ne, da);
    do_reset();
    chk("midrst_avg", int'(avg_pixel), int'(DEF));
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pulses", int'(avg_done) + int'(sample_err), 0);

    // Randomised traffic against the model.
    ce_r = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) ce_r = ~ce_r;
      cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 499) == 0), ce_r,
            ($urandom_range(0, 63) != 0), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
